// File: rtl/hazard_forward_unit.sv
// Forwarding and hazard unit for the in-order RV32I pipeline.
// Tracks in-flight register writers older than EX in a shadow pipeline of
// DEPTH slots (slot 1 = EX/MEM, slot DEPTH = write-back). For each EX source
// operand it selects the youngest producer whose result is available. If that
// producer's result is not available yet, it stalls EX and injects a bubble.
module hazard_forward_unit #(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3,
  parameter int ADR_W   = 5,
  parameter int SEL_W   = $clog2(DEPTH + 1),
  parameter int CNT_W   = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pipe_hold,
  input  logic                       ex_valid,
  input  logic                       ex_rd_en,
  input  logic [ADR_W-1:0]           ex_rd_adr,
  input  logic [SEL_W-1:0]           ex_rdy_stage,
  input  logic [NUM_SRC*ADR_W-1:0]   ex_rs_adr,
  output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
  output logic                       stall,
  output logic [CNT_W-1:0]           stall_count
);

  // Shadow pipeline: slot k holds the writer that is k stages older than EX.
  logic             slot_v   [1:DEPTH];
  logic [ADR_W-1:0] slot_rd  [1:DEPTH];
  logic [SEL_W-1:0] slot_rdy [1:DEPTH];

  logic             ex_writes;
  logic [SEL_W-1:0] rdy_in;
  logic [NUM_SRC-1:0] hazard;
  logic [NUM_SRC-1:0] found;

  // x0 is hard-wired to zero, so a write to it is not a real producer.
  assign ex_writes = ex_valid & ex_rd_en & (ex_rd_adr != '0);

  // Normalise the ready stage into the tracked range 1..DEPTH.
  always_comb begin
    if (ex_rdy_stage == '0)
      rdy_in = SEL_W'(1);
    else if (ex_rdy_stage > SEL_W'(DEPTH))
      rdy_in = SEL_W'(DEPTH);
    else
      rdy_in = ex_rdy_stage;
  end

  // Per-source lookup: the youngest matching slot decides, ready or not.
  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    fwd_sel = '0;
    hazard  = '0;
    found   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ex_rs_adr[i*ADR_W +: ADR_W] != '0) begin
        for (int k = 1; k <= DEPTH; k++) begin
          if (!found[i] && slot_v[k] &&
              (slot_rd[k] == ex_rs_adr[i*ADR_W +: ADR_W])) begin
            found[i] = 1'b1;
            if (SEL_W'(k) >= slot_rdy[k])
              fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
            else
              hazard[i] = 1'b1;
          end
        end
      end
    end
  end

  // A stall is only meaningful for a live EX instruction; it ignores pipe_hold.
  assign stall = ex_valid & (|hazard);

  // Valid bits and the stall counter: reset, hold, bubble-shift or normal shift.
  // NOTE: sequential state uses non-blocking assignments so all slots shift
  // from their pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= DEPTH; k++)
        slot_v[k] <= 1'b0;
      stall_count <= '0;
    end else if (!pipe_hold) begin
      for (int k = DEPTH; k >= 2; k--)
        slot_v[k] <= slot_v[k-1];
      if (stall) begin
        slot_v[1] <= 1'b0;
        if (stall_count != '1)
          stall_count <= stall_count + 1'b1;
      end else begin
        slot_v[1] <= ex_writes;
      end
    end
  end

  // Slot payload shifts alongside the valid bits.
  // NOTE: payload has no reset; it is never observed while its valid bit is 0.
  always_ff @(posedge clk) begin
    if (!pipe_hold) begin
      for (int k = DEPTH; k >= 2; k--) begin
        slot_rd[k]  <= slot_rd[k-1];
        slot_rdy[k] <= slot_rdy[k-1];
      end
      slot_rd[1]  <= ex_rd_adr;
      slot_rdy[1] <= rdy_in;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit: the driver applies one directed
// vector per cycle and queues the hand-computed response; the monitor pops
// and compares on every falling edge.
module tb_hazard_forward_unit;

  localparam int NUM_SRC = 2;
  localparam int DEPTH   = 3;
  localparam int ADR_W   = 5;
  localparam int SEL_W   = 2;
  localparam int CNT_W   = 32;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     pipe_hold;
  logic                     ex_valid;
  logic                     ex_rd_en;
  logic [ADR_W-1:0]         ex_rd_adr;
  logic [SEL_W-1:0]         ex_rdy_stage;
  logic [NUM_SRC*ADR_W-1:0] ex_rs_adr;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel;
  logic                     stall;
  logic [CNT_W-1:0]         stall_count;

  hazard_forward_unit #(
    .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .ADR_W(ADR_W), .SEL_W(SEL_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .pipe_hold(pipe_hold), .ex_valid(ex_valid),
    .ex_rd_en(ex_rd_en), .ex_rd_adr(ex_rd_adr), .ex_rdy_stage(ex_rdy_stage),
    .ex_rs_adr(ex_rs_adr), .fwd_sel(fwd_sel), .stall(stall),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [1:0]  sel0;
    logic [1:0]  sel1;
    logic        stl;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL step %0d %s: got %0h, expected %0h", idx, name, act, req);
    end
  endtask

  // Apply one vector for one cycle and queue its expected response.
  task automatic step(input logic r, input logic h, input logic v,
                      input logic en, input logic [4:0] rd, input logic [1:0] rdy,
                      input logic [4:0] rs0, input logic [4:0] rs1,
                      input logic [1:0] s0, input logic [1:0] s1,
                      input logic st, input int cnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst          = r;
    pipe_hold    = h;
    ex_valid     = v;
    ex_rd_en     = en;
    ex_rd_adr    = rd;
    ex_rdy_stage = rdy;
    ex_rs_adr    = {rs1, rs0};
    step_no++;
    e.idx  = step_no;
    e.sel0 = s0;
    e.sel1 = s1;
    e.stl  = st;
    e.cnt  = 32'(cnt);
    exp_q.push_back(e);
  endtask

  // Monitor: compare every queued expectation against the outputs mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("fwd_sel0",    e.idx, 32'(fwd_sel[1:0]), 32'(e.sel0));
        check("fwd_sel1",    e.idx, 32'(fwd_sel[3:2]), 32'(e.sel1));
        check("stall",       e.idx, 32'(stall),        32'(e.stl));
        check("stall_count", e.idx, stall_count,       e.cnt);
      end
    end
  end

  initial begin
    rst = 1'b1; pipe_hold = 1'b0; ex_valid = 1'b0; ex_rd_en = 1'b0;
    ex_rd_adr = '0; ex_rdy_stage = '0; ex_rs_adr = '0;

    //    rst h  v  en rd  rdy rs0 rs1  sel0 sel1 stl cnt
    // Reset, then populate slots and reset twice mid-operation.
    step(1, 0, 0, 0, 0,  0, 0,  0,   0, 0, 0, 0);   // 1
    step(0, 0, 1, 1, 5,  1, 0,  0,   0, 0, 0, 0);   // 2
    step(0, 0, 1, 1, 6,  2, 0,  0,   0, 0, 0, 0);   // 3
    step(0, 0, 1, 1, 7,  1, 0,  0,   0, 0, 0, 0);   // 4
    step(1, 0, 1, 1, 8,  1, 7,  6,   1, 2, 0, 0);   // 5 populated, rst rises
    step(1, 0, 1, 1, 8,  1, 7,  6,   0, 0, 0, 0);   // 6 cleared
    // ALU back-to-back forwarding from slots 1, 2 and 3.
    step(0, 0, 1, 1, 5,  1, 7,  6,   0, 0, 0, 0);   // 7
    step(0, 0, 1, 0, 0,  1, 5,  0,   1, 0, 0, 0);   // 8
    step(0, 0, 1, 0, 0,  1, 0,  5,   0, 2, 0, 0);   // 9
    step(0, 0, 1, 0, 0,  1, 5,  5,   3, 3, 0, 0);   // 10
    // Load-use: one stall cycle, then forward from slot 2.
    step(0, 0, 1, 1, 6,  2, 0,  0,   0, 0, 0, 0);   // 11
    step(0, 0, 1, 1, 9,  1, 0,  6,   0, 0, 1, 0);   // 12
    step(0, 0, 1, 1, 9,  1, 0,  6,   0, 2, 0, 1);   // 13
    // Youngest producer wins.
    step(0, 0, 1, 1, 7,  1, 9,  0,   1, 0, 0, 1);   // 14
    step(0, 0, 1, 1, 10, 1, 9,  7,   2, 1, 0, 1);   // 15
    step(0, 0, 1, 1, 7,  1, 7,  10,  2, 1, 0, 1);   // 16
    step(0, 0, 1, 0, 0,  1, 7,  0,   1, 0, 0, 1);   // 17 x7 in slots 1 and 3
    step(0, 0, 1, 1, 7,  2, 0,  0,   0, 0, 0, 1);   // 18
    step(0, 0, 1, 0, 0,  1, 0,  7,   0, 0, 1, 1);   // 19 unready young beats ready old
    step(0, 0, 1, 0, 0,  1, 0,  7,   0, 2, 0, 2);   // 20
    // x0 and disabled writes are not producers.
    step(0, 0, 1, 1, 0,  1, 0,  0,   0, 0, 0, 2);   // 21
    step(0, 0, 1, 0, 11, 1, 0,  0,   0, 0, 0, 2);   // 22
    step(0, 0, 1, 0, 0,  1, 0,  11,  0, 0, 0, 2);   // 23
    // Load-use under pipe_hold.
    step(0, 0, 1, 1, 12, 2, 0,  0,   0, 0, 0, 2);   // 24
    step(0, 1, 1, 1, 13, 1, 0,  12,  0, 0, 1, 2);   // 25
    step(0, 1, 1, 1, 13, 1, 0,  12,  0, 0, 1, 2);   // 26
    step(0, 1, 1, 1, 13, 1, 0,  12,  0, 0, 1, 2);   // 27
    step(0, 0, 1, 1, 13, 1, 0,  12,  0, 0, 1, 2);   // 28
    step(0, 0, 1, 1, 13, 1, 0,  12,  0, 2, 0, 3);   // 29
    // Ready-stage 0 and 3 producers; rdy 3 in slot 1 stalls two cycles.
    step(0, 0, 1, 1, 14, 0, 13, 12,  1, 3, 0, 3);   // 30
    step(0, 0, 1, 1, 15, 3, 14, 0,   1, 0, 0, 3);   // 31
    step(0, 0, 1, 0, 0,  1, 15, 13,  0, 3, 1, 3);   // 32
    step(0, 0, 1, 0, 0,  1, 15, 13,  0, 0, 1, 4);   // 33
    step(0, 0, 1, 0, 0,  1, 15, 13,  3, 0, 0, 5);   // 34
    // Hazard with no live EX instruction does not stall.
    step(0, 0, 1, 1, 16, 2, 0,  0,   0, 0, 0, 5);   // 35
    step(0, 0, 0, 0, 0,  1, 16, 0,   0, 0, 0, 5);   // 36
    step(0, 0, 1, 0, 0,  1, 16, 0,   2, 0, 0, 5);   // 37
    // Mid-operation reset clears tracking and the counter.
    step(1, 0, 1, 0, 0,  1, 16, 0,   3, 0, 0, 5);   // 38
    step(0, 0, 1, 0, 0,  1, 16, 0,   0, 0, 0, 0);   // 39

    for (int i = 0; i < 10 && exp_q.size() > 0; i++)
      @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
